// File: rtl/bus2_arbiter.sv
// Two-requester bus-2 line-transfer arbiter: round-robin grant, write/read line sequencing, response timeout.
// Grant registers on the edge after REQ_VALID; requesters are held off by GNT until their DONE pulse.
module bus2_arbiter #(
    parameter int         ADDR_W        = 14,
    parameter int         DATA_W        = 16,
    parameter int         LINE_BYTES    = 16,
    parameter int         TIMEOUT       = 200,
    parameter logic [1:0] C2_NOP        = 2'd0,
    parameter logic [1:0] C2_RESPONSE   = 2'd1,
    parameter logic [1:0] C2_READ_LINE  = 2'd2,
    parameter logic [1:0] C2_WRITE_LINE = 2'd3,
    localparam int        BEATS         = LINE_BYTES * 8 / DATA_W,
    localparam int        BEAT_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        REQ_VALID,
    input  logic [1:0]        REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR0,
    input  logic [ADDR_W-1:0] REQ_ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic [1:0]        GNT,
    output logic [BEAT_W-1:0] BEAT,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_VALID,
    output logic [1:0]        DONE,
    output logic              ERR,
    output logic [1:0]        C2_OUT,
    output logic              C2_OE,
    output logic [ADDR_W-1:0] A2_OUT,
    output logic [DATA_W-1:0] D2_OUT,
    output logic              D2_OE,
    input  logic [1:0]        C2_IN,
    input  logic [DATA_W-1:0] D2_IN
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(BEATS - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_BEATS, S_RD_CMD, S_WAIT_RESP, S_RD_BEATS, S_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                wr_q, wr_d;
    logic                ptr_q, ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_vld_q, rdata_vld_d;
    logic [1:0]          done_q, done_d;
    logic                err_q, err_d;
    logic                pick;

    // ptr_q holds the last requester served; resetting it to 1 gives requester 0 first priority
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            wr_q        <= 1'b0;
            ptr_q       <= 1'b1;
            beat_q      <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
        done_d      = 2'b00;
        err_d       = 1'b0;
        pick        = (REQ_VALID == 2'b11) ? ~ptr_q : REQ_VALID[1];
        case (state_q)
            S_IDLE: begin
                if (|REQ_VALID) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    wr_d    = REQ_WRITE[pick];
                    ptr_d   = pick;
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = REQ_WRITE[pick] ? S_WR_BEATS : S_RD_CMD;
                end
            end
            S_WR_BEATS: begin
                if (beat_q == LAST_BEAT) state_d = S_WAIT_RESP;
                else                     beat_d  = beat_q + 1'b1;
            end
            S_RD_CMD: state_d = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (C2_IN == C2_RESPONSE) begin
                    if (wr_q) begin
                        done_d  = gnt_q;
                        gnt_d   = 2'b00;
                        state_d = S_TURN;
                    end else begin
                        rdata_d     = D2_IN;
                        rdata_vld_d = 1'b1;
                        beat_d      = '0;
                        state_d     = S_RD_BEATS;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_BEATS: begin
                rdata_d     = D2_IN;
                rdata_vld_d = 1'b1;
                beat_d      = beat_q + 1'b1;
                if (beat_q == PENULT_BEAT) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = S_TURN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command is issued once at T0; C2_OE stays up through the write burst since the bus is still ours
    always_comb begin
        C2_OUT = C2_NOP;
        C2_OE  = 1'b0;
        D2_OE  = 1'b0;
        D2_OUT = '0;
        A2_OUT = gnt_q[1] ? REQ_ADDR1 : (gnt_q[0] ? REQ_ADDR0 : '0);
        case (state_q)
            S_WR_BEATS: begin
                C2_OE  = 1'b1;
                D2_OE  = 1'b1;
                D2_OUT = gnt_q[1] ? WDATA1 : WDATA0;
                if (beat_q == '0) C2_OUT = C2_WRITE_LINE;
            end
            S_RD_CMD: begin
                C2_OE  = 1'b1;
                C2_OUT = C2_READ_LINE;
            end
            default: ;
        endcase
    end

    assign GNT         = gnt_q;
    assign BEAT        = beat_q;
    assign RDATA       = rdata_q;
    assign RDATA_VALID = rdata_vld_q;
    assign DONE        = done_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_bus2_arbiter.sv
// Directed bench for bus2_arbiter: table of line transactions plus round-robin, reset-abort and spurious-response sequences.
module tb_bus2_arbiter;

    localparam int TIMEOUT = 200;

    logic        CLK, RESET;
    logic [1:0]  REQ_VALID, REQ_WRITE;
    logic [13:0] REQ_ADDR0, REQ_ADDR1;
    logic [15:0] WDATA0, WDATA1;
    logic [1:0]  GNT;
    logic [2:0]  BEAT;
    logic [15:0] RDATA;
    logic        RDATA_VALID;
    logic [1:0]  DONE;
    logic        ERR;
    logic [1:0]  C2_OUT;
    logic        C2_OE;
    logic [13:0] A2_OUT;
    logic [15:0] D2_OUT;
    logic        D2_OE;
    logic [1:0]  C2_IN;
    logic [15:0] D2_IN;

    int n_cmp = 0;
    int n_bad = 0;

    bus2_arbiter dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR0(REQ_ADDR0), .REQ_ADDR1(REQ_ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT(GNT), .BEAT(BEAT), .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .DONE(DONE),
        .ERR(ERR), .C2_OUT(C2_OUT), .C2_OE(C2_OE), .A2_OUT(A2_OUT), .D2_OUT(D2_OUT),
        .D2_OE(D2_OE), .C2_IN(C2_IN), .D2_IN(D2_IN)
    );

    // Requesters present the beat selected by BEAT: req0 tags its data with 0xA000, req1 sends the bare index
    assign WDATA0 = 16'hA000 | {13'b0, BEAT};
    assign WDATA1 = {13'b0, BEAT};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          rid;
        bit          wr;
        logic [13:0] addr;
        int          delay;
        logic [1:0]  exp_gnt;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " GNT"}, 32'(GNT), 32'd0);
        chk({tag, " DONE"}, 32'(DONE), 32'd0);
        chk({tag, " ERR"}, 32'(ERR), 32'd0);
        chk({tag, " RDATA_VALID"}, 32'(RDATA_VALID), 32'd0);
        chk({tag, " BEAT"}, 32'(BEAT), 32'd0);
        chk({tag, " C2_OUT"}, 32'(C2_OUT), 32'd0);
        chk({tag, " C2_OE"}, 32'(C2_OE), 32'd0);
        chk({tag, " D2_OE"}, 32'(D2_OE), 32'd0);
        chk({tag, " A2_OUT"}, 32'(A2_OUT), 32'd0);
        chk({tag, " D2_OUT"}, 32'(D2_OUT), 32'd0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the TURN cycle
    task automatic run_vec(input vec_t v);
        logic [15:0] wbase;
        wbase = (v.rid == 0) ? 16'hA000 : 16'h0000;
        REQ_VALID[v.rid] = 1'b1;
        REQ_WRITE[v.rid] = v.wr;
        if (v.rid == 0) REQ_ADDR0 = v.addr; else REQ_ADDR1 = v.addr;
        @(negedge CLK);
        chk("t0 GNT", 32'(GNT), 32'(v.exp_gnt));
        chk("t0 A2_OUT", 32'(A2_OUT), 32'(v.addr));
        chk("t0 C2_OE", 32'(C2_OE), 32'd1);
        if (v.wr) begin
            chk("wr C2_OUT", 32'(C2_OUT), 32'd3);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) @(negedge CLK);
                chk("wr D2_OE", 32'(D2_OE), 32'd1);
                chk("wr BEAT", 32'(BEAT), 32'(k));
                chk("wr D2_OUT", 32'(D2_OUT), 32'(wbase | 16'(k)));
                if (k == 1) chk("wr C2_OUT after T0", 32'(C2_OUT), 32'd0);
            end
        end else begin
            chk("rd C2_OUT", 32'(C2_OUT), 32'd2);
            chk("rd D2_OE", 32'(D2_OE), 32'd0);
        end
        @(negedge CLK);
        chk("wait C2_OE", 32'(C2_OE), 32'd0);
        chk("wait D2_OE", 32'(D2_OE), 32'd0);
        chk("wait GNT", 32'(GNT), 32'(v.exp_gnt));
        if (v.delay >= TIMEOUT) begin
            repeat (TIMEOUT - 1) @(negedge CLK);
            chk("pre-timeout ERR", 32'(ERR), 32'd0);
            chk("pre-timeout DONE", 32'(DONE), 32'd0);
            @(negedge CLK);
            chk("timeout ERR", 32'(ERR), 32'(v.exp_err));
            chk("timeout DONE", 32'(DONE), 32'(v.exp_gnt));
        end else begin
            repeat (v.delay) @(negedge CLK);
            C2_IN = 2'd1;
            D2_IN = 16'h0100;
            @(negedge CLK);
            C2_IN = 2'd0;
            if (v.wr) begin
                chk("wr DONE", 32'(DONE), 32'(v.exp_gnt));
                chk("wr ERR", 32'(ERR), 32'(v.exp_err));
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) begin
                        D2_IN = 16'h0100 + 16'(k);
                        @(negedge CLK);
                    end
                    chk("rd RDATA", 32'(RDATA), 32'(16'h0100 + 16'(k)));
                    chk("rd RDATA_VALID", 32'(RDATA_VALID), 32'd1);
                    chk("rd BEAT", 32'(BEAT), 32'(k));
                    chk("rd DONE", 32'(DONE), (k == 7) ? 32'(v.exp_gnt) : 32'd0);
                end
                chk("rd ERR", 32'(ERR), 32'(v.exp_err));
            end
        end
        REQ_VALID[v.rid] = 1'b0;
        chk("turn GNT", 32'(GNT), 32'd0);
        chk("turn C2_OE", 32'(C2_OE), 32'd0);
        @(negedge CLK);
        chk("idle DONE", 32'(DONE), 32'd0);
        chk("idle ERR", 32'(ERR), 32'd0);
        chk("idle RDATA_VALID", 32'(RDATA_VALID), 32'd0);
    endtask

    initial begin
        tbl[0] = '{rid: 0, wr: 1'b0, addr: 14'h0A5, delay: 10,  exp_gnt: 2'b01, exp_err: 1'b0};
        tbl[1] = '{rid: 1, wr: 1'b1, addr: 14'h1FF, delay: 3,   exp_gnt: 2'b10, exp_err: 1'b0};
        tbl[2] = '{rid: 0, wr: 1'b1, addr: 14'h123, delay: 0,   exp_gnt: 2'b01, exp_err: 1'b0};
        tbl[3] = '{rid: 1, wr: 1'b0, addr: 14'h3C3, delay: 0,   exp_gnt: 2'b10, exp_err: 1'b0};
        tbl[4] = '{rid: 1, wr: 1'b1, addr: 14'h055, delay: 200, exp_gnt: 2'b10, exp_err: 1'b1};
        tbl[5] = '{rid: 0, wr: 1'b0, addr: 14'h2AA, delay: 2,   exp_gnt: 2'b01, exp_err: 1'b0};

        RESET = 1'b1;
        REQ_VALID = 2'b00; REQ_WRITE = 2'b00;
        REQ_ADDR0 = '0; REQ_ADDR1 = '0;
        C2_IN = 2'd0; D2_IN = '0;
        repeat (2) @(negedge CLK);
        chk_idle_outputs("reset");
        chk("reset RDATA", 32'(RDATA), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Both requesting from reset: expect 0,1,0,1 with a TURN gap between grants
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        REQ_ADDR0 = 14'h011; REQ_ADDR1 = 14'h022;
        REQ_WRITE = 2'b11;
        REQ_VALID = 2'b11;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] eg;
            eg = (n % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge CLK);
            chk("rr GNT", 32'(GNT), 32'(eg));
            repeat (8) @(negedge CLK);
            C2_IN = 2'd1;
            @(negedge CLK);
            C2_IN = 2'd0;
            chk("rr turn DONE", 32'(DONE), 32'(eg));
            chk("rr turn GNT", 32'(GNT), 32'd0);
            @(negedge CLK);
            chk("rr idle GNT", 32'(GNT), 32'd0);
        end
        REQ_VALID = 2'b00;
        @(negedge CLK);

        // Reset during write beat 4 aborts without DONE
        REQ_VALID = 2'b10; REQ_WRITE = 2'b10; REQ_ADDR1 = 14'h1FF;
        repeat (5) @(negedge CLK);
        chk("abort BEAT before reset", 32'(BEAT), 32'd4);
        RESET = 1'b1;
        @(negedge CLK);
        chk_idle_outputs("abort");
        RESET = 1'b0;
        REQ_VALID = 2'b00;
        @(negedge CLK);
        chk("post-abort DONE", 32'(DONE), 32'd0);

        // A stray RESPONSE while idle must not produce anything
        C2_IN = 2'd1;
        D2_IN = 16'hDEAD;
        repeat (2) @(negedge CLK);
        C2_IN = 2'd0;
        chk_idle_outputs("spurious");
        @(negedge CLK);
        chk("spurious RDATA_VALID", 32'(RDATA_VALID), 32'd0);

        run_vec(tbl[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus2_arbiter.md
BUS2_ARBITER -- requirements
Module: bus2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, line address width (tag+set) driven on bus 2.
REQ-002 SHALL have parameter DATA_W, default 16, bus-2 data beat width.
REQ-003 SHALL have parameter LINE_BYTES, default 16, cache line size; BEATS = LINE_BYTES*8/DATA_W (default 8).
REQ-004 SHALL have parameter TIMEOUT, default 200, maximum cycles waiting for C2_RESPONSE.
REQ-005 SHALL have parameters C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3 (2-bit codes).
REQ-006 SHALL have port CLK  in  1  clock.
REQ-007 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port REQ_VALID  in  2  per-requester transaction request, held until DONE.
REQ-009 SHALL have port REQ_WRITE  in  2  per-requester 1 = write line, 0 = read line.
REQ-010 SHALL have ports REQ_ADDR0, REQ_ADDR1  in  ADDR_W  line address, stable while REQ_VALID.
REQ-011 SHALL have ports WDATA0, WDATA1  in  DATA_W  write beat selected by BEAT, little-endian bytes.
REQ-012 SHALL have port GNT  out  2  one-hot grant, held for the whole transaction.
REQ-013 SHALL have port BEAT  out  $clog2(BEATS)  current beat index.
REQ-014 SHALL have port RDATA  out  DATA_W  read beat; RDATA_VALID  out  1  qualifies RDATA.
REQ-015 SHALL have port DONE  out  2  one-cycle completion pulse to granted requester; ERR  out  1  timeout pulse.
REQ-016 SHALL have ports C2_OUT  out  2, C2_OE  out  1, A2_OUT  out  ADDR_W, D2_OUT  out  DATA_W, D2_OE  out  1  bus-2 drive side.
REQ-017 SHALL have ports C2_IN  in  2, D2_IN  in  DATA_W  bus-2 sample side.

Function
REQ-018 SHALL implement states IDLE, WR_BEATS, RD_CMD, WAIT_RESP, RD_BEATS, TURN.
REQ-019 IDLE: any REQ_VALID -> grant same edge; if both, grant the requester not served last (round-robin pointer).
REQ-020 Pointer SHALL update at grant to the granted index; after reset requester 0 has priority.
REQ-021 Write, first granted cycle T0: C2_OUT=C2_WRITE_LINE, C2_OE=1, A2_OUT=granted address, D2_OE=1, D2_OUT=WDATA(BEAT=0).
REQ-022 Write: BEAT increments each cycle; beat k driven in cycle Tk; after beat BEATS-1 -> WAIT_RESP with C2_OE=D2_OE=0.
REQ-023 Read, T0: C2_OUT=C2_READ_LINE, C2_OE=1, A2_OUT=address, D2_OE=0; T1 -> WAIT_RESP with C2_OE=0.
REQ-024 WAIT_RESP: count cycles; on C2_IN==C2_RESPONSE: write -> DONE pulse, go TURN; read -> capture D2_IN as beat 0, RDATA_VALID=1, BEAT=0, go RD_BEATS.
REQ-025 RD_BEATS: capture one beat per cycle, RDATA_VALID=1, BEAT 1..BEATS-1; DONE pulses with last beat; then TURN.
REQ-026 Response-wait counter reaching TIMEOUT without C2_RESPONSE: ERR and DONE pulse together, -> TURN.
REQ-027 TURN: one idle cycle, all OE=0, GNT=0; then IDLE; no back-to-back grant without TURN.
REQ-028 REQ_VALID deassertion mid-transaction SHALL be ignored; transaction completes.
REQ-029 C2_IN==C2_RESPONSE outside WAIT_RESP SHALL be ignored.
REQ-030 C2_OE/D2_OE SHALL never be 1 in WAIT_RESP, RD_BEATS, TURN, IDLE.
REQ-031 BEAT SHALL not wrap within a transaction; resets to 0 at each grant.

Reset
REQ-032 While RESET=1: GNT=0, DONE=0, ERR=0, RDATA_VALID=0, RDATA=0, BEAT=0, C2_OUT=C2_NOP, C2_OE=0, D2_OE=0, A2_OUT=0, D2_OUT=0, state IDLE, pointer favors requester 0.
REQ-033 RESET mid-transaction SHALL abort immediately, releasing bus with no DONE pulse.

Verification
REQ-034 Req0 read 0x0A5, memory responds after 10 cycles with beats 0x0100..0x0107 -> GNT=01, RDATA sequence 0x0100..0x0107, DONE[0] on 8th beat.
REQ-035 Req1 write 0x1FF, WDATA1=beat index -> C2_OUT=3 one cycle, D2_OUT 0..7 on T0..T7, DONE[1] the cycle of RESPONSE.
REQ-036 Both REQ_VALID from reset -> req0 served, TURN cycle, then req1; repeat both -> order 0,1,0,1.
REQ-037 No response for 200 cycles -> ERR=1 and DONE pulse same cycle, bus released, next request granted normally.
REQ-038 RESET asserted during write beat 4 -> all outputs reset values next sample, no DONE; spurious RESPONSE in IDLE ignored.
